// File: rtl/ram_controller.sv
// ram_controller: turns a single 32-bit word read or write into one MIG 7-series app command (128-bit chunk).
// Optional read timeout is enabled by defining RAM_CTRL_RD_TIMEOUT_EN.
module ram_controller #(
  parameter int CHUNK_PART     = 128,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE/8,
  parameter int ADDRESS_SIZE   = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [MASK_SIZE-1:0]    mask,
  output logic                    controller_ready,
  output logic [3:0]              error,
  input  logic                    write_trigger,
  input  logic [DATA_SIZE-1:0]    write_value,
  input  logic                    read_trigger,
  output logic [DATA_SIZE-1:0]    read_value,
  output logic                    read_value_ready,
  output logic [ADDRESS_SIZE-1:0] mig_app_addr,
  output logic [2:0]              mig_app_cmd,
  output logic                    mig_app_en,
  output logic [CHUNK_PART-1:0]   mig_app_wdf_data,
  output logic                    mig_app_wdf_end,
  output logic [CHUNK_PART/8-1:0] mig_app_wdf_mask,
  output logic                    mig_app_wdf_wren,
  input  logic [CHUNK_PART-1:0]   mig_app_rd_data,
  input  logic                    mig_app_rd_data_end,
  input  logic                    mig_app_rd_data_valid,
  input  logic                    mig_app_rdy,
  input  logic                    mig_app_wdf_rdy,
  input  logic                    mig_init_calib_complete
);
  localparam int WORDS = CHUNK_PART/DATA_SIZE;
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR} state_t;
  state_t state;
  logic [1:0] slot;
  logic [3:0] err;
  logic [CHUNK_PART/8-1:0] new_mask;
  logic accept, timeout, unused;
  assign controller_ready = rst_n && state == IDLE && mig_init_calib_complete;
  assign accept = controller_ready && (read_trigger || write_trigger);
  assign error = err;
  assign mig_app_wdf_end = mig_app_wdf_wren;
  assign unused = ^{mig_app_rd_data_end, address[ADDRESS_SIZE-1]};
  // MIG mask is inverted sense: only the selected word's bytes may be cleared
  always_comb begin
    new_mask = '1;
    new_mask[MASK_SIZE*address[1:0] +: MASK_SIZE] = ~mask;
  end
`ifdef RAM_CTRL_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES-1);
  logic [TW-1:0] tcnt;
  logic reading;
  assign reading = state == RD_CMD || state == RD_WAIT;
  assign timeout = reading && tcnt == TLAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= reading ? tcnt + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      slot             <= '0;
      err              <= '0;
      read_value       <= '0;
      read_value_ready <= 1'b0;
      mig_app_addr     <= '0;
      mig_app_cmd      <= '0;
      mig_app_en       <= 1'b0;
      mig_app_wdf_data <= '0;
      mig_app_wdf_mask <= '1;
      mig_app_wdf_wren <= 1'b0;
    end else begin
      read_value_ready <= 1'b0;
      if ((read_trigger || write_trigger) && !controller_ready) err[0] <= 1'b1;
      if (read_trigger && write_trigger && controller_ready) err[1] <= 1'b1;
      if (mig_app_rd_data_valid && state != RD_WAIT) err[2] <= 1'b1;
      if (timeout) err[3] <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          slot             <= address[1:0];
          mig_app_addr     <= {address[ADDRESS_SIZE-2:2], 3'b000};
          mig_app_en       <= 1'b1;
          mig_app_cmd      <= write_trigger ? 3'b000 : 3'b001;
          mig_app_wdf_wren <= write_trigger;
          mig_app_wdf_data <= {WORDS{write_value}};
          mig_app_wdf_mask <= write_trigger ? new_mask : '1;
          state            <= write_trigger ? WR : RD_CMD;
        end
        RD_CMD: if (mig_app_rdy) begin
          mig_app_en <= 1'b0;
          state      <= RD_WAIT;
        end
        RD_WAIT: if (mig_app_rd_data_valid) begin
          read_value       <= mig_app_rd_data[DATA_SIZE*slot +: DATA_SIZE];
          read_value_ready <= 1'b1;
          state            <= IDLE;
        end
        WR: begin
          if (mig_app_rdy) mig_app_en <= 1'b0;
          if (mig_app_wdf_rdy) mig_app_wdf_wren <= 1'b0;
          if ((!mig_app_en || mig_app_rdy) && (!mig_app_wdf_wren || mig_app_wdf_rdy)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (timeout) begin
        read_value       <= DATA_SIZE'(32'hDEADBEEF);
        read_value_ready <= 1'b1;
        mig_app_en       <= 1'b0;
        state            <= IDLE;
      end
    end
endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: directed stimulus with queue-based scoreboard for ram_controller.
module tb_ram_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [27:0] address = '0;
  logic [3:0] mask = '0;
  logic write_trigger = 1'b0, read_trigger = 1'b0;
  logic [31:0] write_value = '0;
  logic [127:0] mig_app_rd_data = '0;
  logic mig_app_rd_data_end = 1'b0, mig_app_rd_data_valid = 1'b0;
  logic mig_app_rdy = 1'b1, mig_app_wdf_rdy = 1'b1, mig_init_calib_complete = 1'b0;
  logic controller_ready, read_value_ready, mig_app_en, mig_app_wdf_end, mig_app_wdf_wren;
  logic [3:0] error;
  logic [31:0] read_value;
  logic [27:0] mig_app_addr;
  logic [2:0] mig_app_cmd;
  logic [127:0] mig_app_wdf_data;
  logic [15:0] mig_app_wdf_mask;

  ram_controller dut (
    .clk(clk), .rst_n(rst_n), .address(address), .mask(mask),
    .controller_ready(controller_ready), .error(error),
    .write_trigger(write_trigger), .write_value(write_value),
    .read_trigger(read_trigger), .read_value(read_value), .read_value_ready(read_value_ready),
    .mig_app_addr(mig_app_addr), .mig_app_cmd(mig_app_cmd), .mig_app_en(mig_app_en),
    .mig_app_wdf_data(mig_app_wdf_data), .mig_app_wdf_end(mig_app_wdf_end),
    .mig_app_wdf_mask(mig_app_wdf_mask), .mig_app_wdf_wren(mig_app_wdf_wren),
    .mig_app_rd_data(mig_app_rd_data), .mig_app_rd_data_end(mig_app_rd_data_end),
    .mig_app_rd_data_valid(mig_app_rd_data_valid), .mig_app_rdy(mig_app_rdy),
    .mig_app_wdf_rdy(mig_app_wdf_rdy), .mig_init_calib_complete(mig_init_calib_complete)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] cmd; logic [27:0] addr; } cmd_t;
  typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
  cmd_t cmd_q[$];
  wd_t wd_q[$];
  logic [31:0] rd_q[$];
  cmd_t mc;
  wd_t md;
  logic [31:0] mr;
  int checks = 0, failures = 0, en_cnt = 0, wr_cnt = 0, cmd_seen = 0, exp_cmds = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake or strobes read data
  initial forever begin
    @(negedge clk);
    if (mig_app_en) en_cnt++;
    if (mig_app_wdf_wren) wr_cnt++;
    if (mig_app_en && mig_app_rdy) begin
      cmd_seen++;
      if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        mc = cmd_q.pop_front();
        chk("app_cmd", mig_app_cmd, mc.cmd);
        chk("app_addr", mig_app_addr, mc.addr);
      end
    end
    if (mig_app_wdf_wren && mig_app_wdf_rdy) begin
      if (wd_q.size() == 0) chk("unexpected_wdf", 1, 0);
      else begin
        md = wd_q.pop_front();
        chk("wdf_data", mig_app_wdf_data, md.data);
        chk("wdf_mask", mig_app_wdf_mask, md.mask);
        chk("wdf_end", mig_app_wdf_end, 1);
      end
    end
    if (read_value_ready) begin
      if (rd_q.size() == 0) chk("unexpected_read_pulse", 1, 0);
      else begin
        mr = rd_q.pop_front();
        chk("read_value", read_value, mr);
      end
    end
  end

  task automatic wait_ready();
    for (int j = 0; j < 40 && !controller_ready; j++) begin @(posedge clk); #1; end
    chk("ready_return", controller_ready, 1);
  endtask

  task automatic do_read(input logic [27:0] a, input logic [127:0] chunk, input logic [31:0] exp_v,
                         input logic [27:0] exp_a, input int rdy_d, input int resp_d, input bit poke);
    cmd_t t;
    t.cmd = 3'b001; t.addr = exp_a;
    cmd_q.push_back(t); rd_q.push_back(exp_v); exp_cmds++;
    @(posedge clk); #1; read_trigger = 1; address = a;
    @(posedge clk); #1; read_trigger = 0; address = 28'h0FFFFFF;
    for (int j = 1; j <= 40 && mig_app_en; j++) begin
      mig_app_rdy = j > rdy_d;
      write_trigger = poke && j == 1;
      @(posedge clk); #1;
    end
    write_trigger = 0; mig_app_rdy = 1;
    chk("rd_cmd_done", mig_app_en, 0);
    repeat (resp_d) begin @(posedge clk); #1; end
    mig_app_rd_data = chunk; mig_app_rd_data_valid = 1;
    @(posedge clk); #1; mig_app_rd_data_valid = 0; mig_app_rd_data = '0;
    wait_ready();
  endtask

  task automatic do_write(input logic [27:0] a, input logic [31:0] v, input logic [3:0] m,
                          input int en_d, input int wr_d, input bit both,
                          input logic [27:0] exp_a, input logic [15:0] exp_m);
    cmd_t t;
    wd_t w;
    int e0, w0;
    t.cmd = 3'b000; t.addr = exp_a;
    w.data = {4{v}}; w.mask = exp_m;
    cmd_q.push_back(t); wd_q.push_back(w); exp_cmds++;
    e0 = en_cnt; w0 = wr_cnt;
    @(posedge clk); #1; write_trigger = 1; read_trigger = both; address = a; mask = m; write_value = v;
    @(posedge clk); #1; write_trigger = 0; read_trigger = 0; address = 28'h0FFFFFF; mask = 4'h0; write_value = 32'hFFFFFFFF;
    for (int j = 1; j <= 40 && !controller_ready; j++) begin
      mig_app_rdy = j > en_d;
      mig_app_wdf_rdy = j > wr_d;
      @(posedge clk); #1;
    end
    mig_app_rdy = 1; mig_app_wdf_rdy = 1;
    chk("wr_ready_return", controller_ready, 1);
    chk("wr_en_cycles", en_cnt - e0, en_d + 1);
    chk("wr_wren_cycles", wr_cnt - w0, wr_d + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", controller_ready, 0);
    chk("rst_error", error, 0);
    chk("rst_en", mig_app_en, 0);
    chk("rst_wren", mig_app_wdf_wren, 0);
    chk("rst_wdf_mask", mig_app_wdf_mask, 16'hFFFF);
    chk("rst_read_value", read_value, 0);
    chk("rst_read_ready", read_value_ready, 0);
    rst_n = 1; mig_init_calib_complete = 1;
    @(posedge clk); #1;
    chk("ready_after_calib", controller_ready, 1);

    do_read(28'd100, {96'd0, 32'hCAFEBABE}, 32'hCAFEBABE, 28'd200, 0, 0, 0);
    do_read(28'd101, {64'd0, 32'h11223344, 32'h55555555}, 32'h11223344, 28'd200, 2, 3, 0);
    do_write(28'd200, 32'h12345678, 4'b1111, 0, 0, 0, 28'd400, 16'hFFF0);
    chk("read_hold", read_value, 32'h11223344);
    do_write(28'd201, 32'hA1B2C3D4, 4'b0011, 3, 1, 0, 28'd400, 16'hFFCF);
    chk("err_clean", error, 0);

    do_read(28'd102, {32'd0, 32'hA5A5A5A5, 64'd0}, 32'hA5A5A5A5, 28'd200, 2, 1, 1);
    do_write(28'd203, 32'h0BADF00D, 4'b0101, 0, 0, 1, 28'd400, 16'hAFFF);
    @(posedge clk); #1; mig_app_rd_data_valid = 1;
    @(posedge clk); #1; mig_app_rd_data_valid = 0;
    chk("err_flags", error, 4'b0111);

`ifdef RAM_CTRL_RD_TIMEOUT_EN
    begin
      cmd_t t;
      t.cmd = 3'b001; t.addr = 28'd16;
      cmd_q.push_back(t); rd_q.push_back(32'hDEADBEEF); exp_cmds++;
      @(posedge clk); #1; read_trigger = 1; address = 28'd8;
      @(posedge clk); #1; read_trigger = 0;
      for (int j = 0; j < 1100 && !controller_ready; j++) begin @(posedge clk); #1; end
      chk("timeout_ready", controller_ready, 1);
      chk("timeout_err", error, 4'b1111);
      chk("timeout_value", read_value, 32'hDEADBEEF);
    end
`endif

    @(posedge clk); #1; mig_app_rdy = 0; read_trigger = 1; address = 28'd300;
    @(posedge clk); #1; read_trigger = 0;
    chk("midop_en", mig_app_en, 1);
    rst_n = 0; #1;
    chk("midop_rst_en", mig_app_en, 0);
    chk("midop_rst_err", error, 0);
    chk("midop_rst_ready", controller_ready, 0);
    @(posedge clk); #1; rst_n = 1; mig_app_rdy = 1;
    @(posedge clk); #1;
    chk("midop_ready_again", controller_ready, 1);

    mig_init_calib_complete = 0; #1;
    chk("calib_low_ready", controller_ready, 0);
    read_trigger = 1; address = 28'd40;
    @(posedge clk); #1; read_trigger = 0; mig_init_calib_complete = 1;
    @(posedge clk); #1;
    chk("calib_block_err", error, 4'b0001);
    chk("calib_block_en", mig_app_en, 0);
    chk("calib_ready_again", controller_ready, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("wd_q_empty", wd_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("cmd_count", cmd_seen, exp_cmds);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
